// File: rtl/drum_pkg.sv
// Shared types and default constants for the drum input front-end.
package drum_pkg;

   // One-hot so that output decodes are single-bit and glitch-free.
   typedef enum logic [3:0] {
      ST_IDLE     = 4'b0001,
      ST_HIT      = 4'b0010,
      ST_LOCKOUT  = 4'b0100,
      ST_WAIT_REL = 4'b1000
   } state_t;

   localparam int unsigned SAMPLE_CYCLES_50MHZ  = 2_500_000;
   localparam int unsigned LOCKOUT_CYCLES_50MHZ = 5_000_000;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/drum_debounce.sv
// 2-FF synchroniser plus sample-based debouncer with a registered rising-edge pulse.
module drum_debounce #(
   parameter int STABLE_SAMPLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   input  logic tick,
   output logic level,
   output logic rise
);

   logic [1:0] sync;
   logic [3:0] agree;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         agree <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         rise <= 1'b0;
         if (tick) begin
            if (sync[1] != level) begin
               // The Nth consecutive disagreeing sample flips the level.
               if (agree == 4'(STABLE_SAMPLES - 1)) begin
                  level <= ~level;
                  agree <= '0;
                  rise  <= ~level;
               end else begin
                  agree <= agree + 4'd1;
               end
            end else begin
               agree <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/drum_input_conditioner.sv
// Drum front-end: debounces piezo and direction button, emits strike/direction events.
// Optional saturating hit counter enabled by defining DRUM_HIT_COUNT_EN.
module drum_input_conditioner
   import drum_pkg::*;
#(
   parameter int unsigned SAMPLE_CYCLES  = SAMPLE_CYCLES_50MHZ,
   parameter int          STABLE_SAMPLES = 2,
   parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_50MHZ,
   parameter int          CNT_W          = 23
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        PIEZO,
   input  logic        UP_DOWN,
   output logic        STRIKE,
   output logic        DIR,
   output logic        DIR_CHG,
   output logic        PIEZO_LVL,
   output logic        BUSY,
   output logic [15:0] HIT_COUNT
);

   logic [CNT_W-1:0] pre_cnt;
   logic             tick;
   logic             piezo_lvl, piezo_rise;
   logic             btn_lvl, btn_rise;
   logic             dir, dir_chg;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] lock_cnt;
   logic             lock_done;
   logic             strike, busy;

   // Shared sample prescaler for both debouncers.
   assign tick = (pre_cnt == CNT_W'(SAMPLE_CYCLES - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) pre_cnt <= '0;
      else        pre_cnt <= tick ? '0 : pre_cnt + CNT_W'(1);
   end

   drum_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_piezo_db (
      .clk   (CLK),
      .rst_n (RST_N),
      .raw   (PIEZO),
      .tick  (tick),
      .level (piezo_lvl),
      .rise  (piezo_rise)
   );

   drum_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_btn_db (
      .clk   (CLK),
      .rst_n (RST_N),
      .raw   (UP_DOWN),
      .tick  (tick),
      .level (btn_lvl),
      .rise  (btn_rise)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dir     <= DIR_UP;
         dir_chg <= 1'b0;
      end else begin
         dir_chg <= btn_rise && btn_lvl;
         if (btn_rise && btn_lvl) dir <= ~dir;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (piezo_rise) state_nxt = ST_HIT;
         ST_HIT:      state_nxt = ST_LOCKOUT;
         ST_LOCKOUT:  if (lock_done) state_nxt = piezo_lvl ? ST_WAIT_REL : ST_IDLE;
         ST_WAIT_REL: if (!piezo_lvl) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      strike = state[1];
      busy   = state[1] | state[2] | state[3];
   end

   // Loaded in HIT so LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
   assign lock_done = (lock_cnt == '0);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                                lock_cnt <= '0;
      else if (state == ST_HIT)                  lock_cnt <= CNT_W'(LOCKOUT_CYCLES - 1);
      else if (state == ST_LOCKOUT && !lock_done) lock_cnt <= lock_cnt - CNT_W'(1);
   end

`ifdef DRUM_HIT_COUNT_EN
   logic [15:0] hit_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                                  hit_cnt <= '0;
      else if (state == ST_HIT && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
   end

   assign HIT_COUNT = hit_cnt;
`else
   assign HIT_COUNT = 16'h0000;
`endif

   assign STRIKE    = strike;
   assign BUSY      = busy;
   assign DIR       = dir;
   assign DIR_CHG   = dir_chg;
   assign PIEZO_LVL = piezo_lvl;

endmodule

// File: tb/tb_drum_input_conditioner.sv
// Directed bench for drum_input_conditioner with short sim timing constants.
module tb_drum_input_conditioner;

   localparam int SC = 4;
   localparam int SS = 2;
   localparam int LC = 20;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        PIEZO = 1'b0;
   logic        UP_DOWN = 1'b0;
   logic        STRIKE, DIR, DIR_CHG, PIEZO_LVL, BUSY;
   logic [15:0] HIT_COUNT;

   int n_asrt = 0;
   int n_fail = 0;
   int edge_n = 0;
   int strike_total = 0;
   int dirchg_total = 0;
   int busy_run = 0;
   int busy_last = 0;
   int lat, s0, d0;

   always #5 CLK = ~CLK;

   drum_input_conditioner #(
      .SAMPLE_CYCLES  (SC),
      .STABLE_SAMPLES (SS),
      .LOCKOUT_CYCLES (LC),
      .CNT_W          (23)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .PIEZO     (PIEZO),
      .UP_DOWN   (UP_DOWN),
      .STRIKE    (STRIKE),
      .DIR       (DIR),
      .DIR_CHG   (DIR_CHG),
      .PIEZO_LVL (PIEZO_LVL),
      .BUSY      (BUSY),
      .HIT_COUNT (HIT_COUNT)
   );

   // Edge count since reset release; sample ticks land on edges with edge_n % 4 == 0.
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   always @(negedge CLK) begin
      if (STRIKE === 1'b1)  strike_total <= strike_total + 1;
      if (DIR_CHG === 1'b1) dirchg_total <= dirchg_total + 1;
      if (BUSY === 1'b1) busy_run <= busy_run + 1;
      else begin
         if (busy_run != 0) busy_last <= busy_run;
         busy_run <= 0;
      end
   end

   function automatic int hc(input int n);
`ifdef DRUM_HIT_COUNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // lat = index of the negedge (counting from the current drive point) where STRIKE shows; -1 on timeout.
   task automatic wait_strike(input int budget, output int l);
      l = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge CLK);
         if (STRIKE === 1'b1) begin
            l = i;
            break;
         end
      end
   endtask

   task automatic do_reset();
      PIEZO   = 1'b0;
      UP_DOWN = 1'b0;
      RST_N   = 1'b0;
      step(3);
      RST_N   = 1'b1;
   endtask

   initial begin
      #2 RST_N = 1'b0;
      step(2);
      chk("rst_strike",    32'(STRIKE),    32'd0);
      chk("rst_dir",       32'(DIR),       32'd0);
      chk("rst_dir_chg",   32'(DIR_CHG),   32'd0);
      chk("rst_piezo_lvl", 32'(PIEZO_LVL), 32'd0);
      chk("rst_busy",      32'(BUSY),      32'd0);
      chk("rst_hit_count", 32'(HIT_COUNT), 32'd0);
      RST_N = 1'b1;

      // Clean hit
      step(5);
      s0 = strike_total;
      PIEZO = 1'b1;
      wait_strike(30, lat);
      chk("clean_latency", 32'(lat >= 9 && lat <= 12), 32'd1);
      chk("clean_busy_at_strike", 32'(BUSY), 32'd1);
      step(40 - lat);
      PIEZO = 1'b0;
      step(40);
      chk("clean_strikes", 32'(strike_total - s0), 32'd1);
      chk("clean_busy_len", 32'(busy_last >= 21), 32'd1);
      chk("clean_idle", 32'({BUSY, PIEZO_LVL}), 32'd0);
      chk("clean_hit_count", 32'(HIT_COUNT), 32'(hc(1)));

      // Bounce, aligned so no two consecutive samples catch a high phase
      do_reset();
      step(5);
      while (edge_n % 2 != 0) step(1);
      s0 = strike_total;
      for (int i = 0; i < 10; i++) begin
         PIEZO = (i % 2 == 0);
         step(3);
      end
      chk("bounce_quiet", 32'(strike_total - s0), 32'd0);
      chk("bounce_lvl_low", 32'(PIEZO_LVL), 32'd0);
      PIEZO = 1'b1;
      wait_strike(30, lat);
      chk("bounce_latency", 32'(lat >= 9 && lat <= 12), 32'd1);
      step(30);
      chk("bounce_strikes", 32'(strike_total - s0), 32'd1);
      chk("bounce_hit_count", 32'(HIT_COUNT), 32'(hc(1)));
      PIEZO = 1'b0;
      step(20);

      // Ringing inside lockout
      do_reset();
      step(5);
      s0 = strike_total;
      PIEZO = 1'b1;
      wait_strike(30, lat);
      chk("ring_latency", 32'(lat >= 9 && lat <= 12), 32'd1);
      step(1);
      PIEZO = 1'b0;
      step(9);
      PIEZO = 1'b1;
      step(20);
      chk("ring_ignored", 32'(strike_total - s0), 32'd1);
      chk("ring_wait_rel_busy", 32'(BUSY), 32'd1);
      PIEZO = 1'b0;
      step(30);
      chk("ring_released", 32'({BUSY, PIEZO_LVL}), 32'd0);
      PIEZO = 1'b1;
      wait_strike(30, lat);
      chk("ring_rehit_latency", 32'(lat >= 9 && lat <= 12), 32'd1);
      step(1);
      PIEZO = 1'b0;
      step(40);
      chk("ring_strikes", 32'(strike_total - s0), 32'd2);
      chk("ring_busy_exact", 32'(busy_last), 32'd21);
      chk("ring_hit_count", 32'(HIT_COUNT), 32'(hc(2)));

      // Held piezo
      do_reset();
      step(5);
      s0 = strike_total;
      PIEZO = 1'b1;
      wait_strike(30, lat);
      chk("held_latency", 32'(lat >= 9 && lat <= 12), 32'd1);
      step(30);
      chk("held_wait_rel", 32'({BUSY, PIEZO_LVL}), 32'd3);
      step(170);
      chk("held_single", 32'(strike_total - s0), 32'd1);
      chk("held_still_busy", 32'(BUSY), 32'd1);
      PIEZO = 1'b0;
      step(20);
      chk("held_release_idle", 32'(BUSY), 32'd0);
      PIEZO = 1'b1;
      wait_strike(30, lat);
      chk("held_repress_latency", 32'(lat >= 9 && lat <= 12), 32'd1);
      step(30);
      chk("held_strikes", 32'(strike_total - s0), 32'd2);
      chk("held_hit_count", 32'(HIT_COUNT), 32'(hc(2)));
      PIEZO = 1'b0;
      step(20);

      // Direction toggle coincident with a strike
      do_reset();
      step(5);
      s0 = strike_total;
      d0 = dirchg_total;
      PIEZO   = 1'b1;
      UP_DOWN = 1'b1;
      wait_strike(30, lat);
      chk("sim_latency", 32'(lat >= 9 && lat <= 12), 32'd1);
      chk("sim_dir_chg", 32'(DIR_CHG), 32'd1);
      chk("sim_dir_new", 32'(DIR), 32'd1);
      step(1);
      chk("sim_dir_chg_pulse", 32'(DIR_CHG), 32'd0);
      PIEZO   = 1'b0;
      UP_DOWN = 1'b0;
      step(30);
      chk("dir_fall_no_effect", 32'(DIR), 32'd1);
      chk("dir_chg_count1", 32'(dirchg_total - d0), 32'd1);
      UP_DOWN = 1'b1;
      step(20);
      chk("dir_second_press", 32'(DIR), 32'd0);
      chk("dir_chg_count2", 32'(dirchg_total - d0), 32'd2);
      chk("dir_strikes", 32'(strike_total - s0), 32'd1);
      UP_DOWN = 1'b0;
      step(20);

      // Reset in the middle of lockout
      do_reset();
      step(5);
      s0 = strike_total;
      PIEZO = 1'b1;
      wait_strike(30, lat);
      chk("rl_latency", 32'(lat >= 9 && lat <= 12), 32'd1);
      step(10);
      chk("rl_busy_before", 32'(BUSY), 32'd1);
      RST_N = 1'b0;
      #1;
      chk("rl_outputs_clear", 32'({STRIKE, DIR, DIR_CHG, PIEZO_LVL, BUSY}), 32'd0);
      chk("rl_hit_count_clear", 32'(HIT_COUNT), 32'd0);
      step(3);
      RST_N = 1'b1;
      wait_strike(30, lat);
      chk("rl_restrike_latency", 32'(lat >= 9 && lat <= 12), 32'd1);
      step(30);
      chk("rl_strikes", 32'(strike_total - s0), 32'd2);
      chk("rl_hit_count", 32'(HIT_COUNT), 32'(hc(1)));
      PIEZO = 1'b0;
      step(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
